// File: rtl/operand_seq_pkg.sv
// Shared types for the operand sequencer: FSM state encoding and index-width helper.
package operand_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Index width for an N-element vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_sequencer_if.sv
// Output pair stream of the operand sequencer (valid/ready handshake towards the MAC).
import operand_seq_pkg::*;

interface operand_sequencer_if #(
  parameter int N = 2,
  parameter int W = 8
);
  localparam int IDX_W = idx_width(N);

  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out1;
  logic [W-1:0]     out2;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (
    output out_valid, out1, out2, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out1, out2, out_idx, out_last,
    output out_ready
  );
endinterface

// File: rtl/operand_sequencer_next_index_finder.sv
// Finds the lowest set mask bit at or above 'from' (pass current index + 1 to get the
// next one). Used only when OPERAND_SEQ_ZERO_SKIP_EN is defined.
module next_index_finder #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W:0]   from,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic             is_last
);
  logic [N-1:0] cand;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = mask[gi] && ((IDX_W+1)'(gi) >= from);
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

  // The found bit is the final one when no other candidate remains.
  assign is_last = ~|(cand & (cand - N'(1)));

endmodule

// File: rtl/operand_sequencer.sv
// Captures input/weight vectors on start and streams (input, weight) pairs one per beat.
// Define OPERAND_SEQ_ZERO_SKIP_EN to skip pairs where either element is zero.
import operand_seq_pkg::*;

module operand_sequencer #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*W-1:0]       InputVec,
  input  logic [N*W-1:0]       WeightVec,
  operand_sequencer_if.master  bus,
  output logic                 busy,
  output logic                 done
);
  localparam int IDX_W = idx_width(N);

  logic [W-1:0]     in_elem [N];
  logic [W-1:0]     wt_elem [N];
  logic [W-1:0]     in_reg  [N];
  logic [W-1:0]     wt_reg  [N];

  seq_state_t       state_reg;
  logic             valid_reg, last_reg, busy_reg, done_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [W-1:0]     out1_reg, out2_reg;

  logic [IDX_W-1:0] first_idx, next_idx;
  logic             first_found, first_last, next_found, next_last;

  // Element 0 sits in the most significant slice.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign in_elem[gi] = InputVec[(N-gi)*W-1 -: W];
      assign wt_elem[gi] = WeightVec[(N-gi)*W-1 -: W];
    end
  endgenerate

`ifdef OPERAND_SEQ_ZERO_SKIP_EN
  logic [N-1:0] mask_in, mask_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign mask_in[gi] = (|in_elem[gi]) && (|wt_elem[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      mask_reg <= mask_in;
    end
  end

  next_index_finder #(.N(N), .IDX_W(IDX_W)) u_first (
    .mask(mask_in), .from('0),
    .idx(first_idx), .found(first_found), .is_last(first_last)
  );

  next_index_finder #(.N(N), .IDX_W(IDX_W)) u_next (
    .mask(mask_reg), .from({1'b0, idx_reg} + (IDX_W+1)'(1)),
    .idx(next_idx), .found(next_found), .is_last(next_last)
  );
`else
  assign first_idx   = '0;
  assign first_found = 1'b1;
  assign first_last  = (N == 1);
  assign next_idx    = idx_reg + IDX_W'(1);
  assign next_found  = 1'b1;
  assign next_last   = (next_idx == IDX_W'(N - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      idx_reg   <= '0;
      out1_reg  <= '0;
      out2_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            in_reg <= in_elem;
            wt_reg <= wt_elem;
            if (first_found) begin
              state_reg <= RUN;
              valid_reg <= 1'b1;
              busy_reg  <= 1'b1;
              idx_reg   <= first_idx;
              out1_reg  <= in_elem[first_idx];
              out2_reg  <= wt_elem[first_idx];
              last_reg  <= first_last;
            end else begin
              // Nothing to present: report completion immediately.
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.out_ready) begin
            if (last_reg || !next_found) begin
              state_reg <= DONE;
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              last_reg  <= 1'b0;
              done_reg  <= 1'b1;
              idx_reg   <= '0;
              out1_reg  <= '0;
              out2_reg  <= '0;
            end else begin
              idx_reg  <= next_idx;
              out1_reg <= in_reg[next_idx];
              out2_reg <= wt_reg[next_idx];
              last_reg <= next_last;
            end
          end
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = valid_reg;
  assign bus.out1      = out1_reg;
  assign bus.out2      = out2_reg;
  assign bus.out_idx   = idx_reg;
  assign bus.out_last  = last_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench: directed sequences push expected pairs, negedge monitors pop and compare.
module tb_operand_sequencer;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          idx;
    bit          last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] in_a = '0, wt_a = '0;
  logic [15:0] in_b = '0, wt_b = '0;
  logic        busy_a, done_a, busy_b, done_b;

  int    checks = 0;
  int    failures = 0;
  beat_t sb_a[$];
  beat_t sb_b[$];

  operand_sequencer_if #(.N(4), .W(8))  ifa();
  operand_sequencer_if #(.N(1), .W(16)) ifb();

  operand_sequencer #(.N(4), .W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .InputVec(in_a), .WeightVec(wt_a),
    .bus(ifa), .busy(busy_a), .done(done_a)
  );

  operand_sequencer #(.N(1), .W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .InputVec(in_b), .WeightVec(wt_b),
    .bus(ifb), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic check_beat(input string n, input beat_t act, input beat_t exp);
    checks++;
    if (act.a !== exp.a || act.b !== exp.b || act.idx != exp.idx || act.last != exp.last) begin
      failures++;
      $display("FAIL %s: got (%0h,%0h,idx%0d,last%0d) expected (%0h,%0h,idx%0d,last%0d)",
               n, act.a, act.b, act.idx, act.last, exp.a, exp.b, exp.idx, exp.last);
    end
  endtask

  task automatic push(input bit sel, input logic [15:0] a, input logic [15:0] b,
                      input int idx, input bit last);
    beat_t e;
    e.a = a; e.b = b; e.idx = idx; e.last = last;
    if (sel) sb_b.push_back(e);
    else     sb_a.push_back(e);
  endtask

  task automatic exp_base();
    push(0, 16'h01, 16'h0A, 0, 0);
    push(0, 16'h02, 16'h0B, 1, 0);
    push(0, 16'h03, 16'h0C, 2, 0);
    push(0, 16'h04, 16'h0D, 3, 1);
  endtask

  // Monitor A: pops on each transfer, and checks a stalled beat is held unchanged.
  beat_t prev_a;
  bit    stall_a = 1'b0;
  always @(negedge clk) begin
    beat_t cur, e;
    cur.a = 16'(ifa.out1); cur.b = 16'(ifa.out2);
    cur.idx = int'(ifa.out_idx); cur.last = ifa.out_last;
    if (rst) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        check("a_hold_valid", 32'(ifa.out_valid), 32'd1);
        check_beat("a_hold", cur, prev_a);
      end
      if (ifa.out_valid && ifa.out_ready) begin
        if (sb_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_unexpected_beat: got idx%0d expected no beat", cur.idx);
        end else begin
          e = sb_a.pop_front();
          check_beat("a_beat", cur, e);
        end
      end
      stall_a = ifa.out_valid && !ifa.out_ready;
      prev_a  = cur;
    end
  end

  always @(negedge clk) begin
    beat_t cur, e;
    cur.a = ifb.out1; cur.b = ifb.out2;
    cur.idx = int'(ifb.out_idx); cur.last = ifb.out_last;
    if (!rst && ifb.out_valid && ifb.out_ready) begin
      if (sb_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_beat: got idx%0d expected no beat", cur.idx);
      end else begin
        e = sb_b.pop_front();
        check_beat("b_beat", cur, e);
      end
    end
  end

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic set_ready(input bit sel, input logic v);
    if (sel) ifb.out_ready = v;
    else     ifa.out_ready = v;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  // hold: keep start high (with other vectors) until the sequence ends.
  // rst_at: cycle in which reset is asserted (0 = never).
  task automatic run_seq(input bit sel, input int mode, input bit hold, input int rst_at,
                         input int exp_done, input string tag);
    int   done_c = 0;
    logic dn, bz, vl;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    if (!hold) begin
      set_start(sel, 1'b0);
    end else begin
      in_a = 32'hDEADBEEF;
      wt_a = 32'h11223344;
    end
    for (int c = 1; c <= 40; c++) begin
      set_ready(sel, (mode == 0) || (c % 3 == 1));
      if (c == rst_at) rst = 1'b1;
      if (rst_at != 0 && c == rst_at + 1) rst = 1'b0;
      if (hold && done_c != 0) set_start(sel, 1'b0);
      @(negedge clk);
      dn = sel ? done_b : done_a;
      bz = sel ? busy_b : busy_a;
      vl = sel ? ifb.out_valid : ifa.out_valid;
      if (rst_at != 0 && c == rst_at + 1) begin
        check({tag, "_valid"}, 32'(ifa.out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_done"}, 32'(done_a), 32'd0);
        check({tag, "_data"}, {ifa.out1, ifa.out2, 6'd0, ifa.out_idx, 7'd0, ifa.out_last}, 32'd0);
        break;
      end
      if (done_c != 0) begin
        check({tag, "_done_pulse"}, 32'(dn), 32'd0);
        check({tag, "_idle_valid"}, 32'(vl), 32'd0);
        check({tag, "_idle_busy"}, 32'(bz), 32'd0);
        break;
      end
      if (dn) begin
        done_c = c;
        check({tag, "_done_valid"}, 32'(vl), 32'd0);
        check({tag, "_done_busy"}, 32'(bz), 32'd0);
      end else if (c == 1) begin
        check({tag, "_first_valid"}, 32'(vl), 32'd1);
        check({tag, "_first_busy"}, 32'(bz), 32'd1);
      end
      @(posedge clk); #1;
    end
    if (rst_at == 0) begin
      check({tag, "_done_cycle"}, 32'(done_c), 32'(exp_done));
      check({tag, "_sb_empty"}, 32'(sel ? sb_b.size() : sb_a.size()), 32'd0);
    end
    set_start(sel, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid_a", 32'(ifa.out_valid), 32'd0);
    check("reset_busy_a", 32'(busy_a), 32'd0);
    check("reset_done_a", 32'(done_a), 32'd0);
    check("reset_valid_b", 32'(ifb.out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    in_a = 32'h01020304;
    wt_a = 32'h0A0B0C0D;
    exp_base(); run_seq(0, 0, 0, 0, 5,  "full");
    exp_base(); run_seq(0, 1, 0, 0, 11, "backpressure");
    exp_base(); run_seq(0, 0, 1, 0, 5,  "start_in_run");
    in_a = 32'h01020304;
    wt_a = 32'h0A0B0C0D;
    exp_base(); run_seq(0, 0, 0, 3, 0,  "mid_rst");
    sb_a.delete();
    exp_base(); run_seq(0, 0, 0, 0, 5,  "replay");

    in_b = 16'h1234;
    wt_b = 16'hABCD;
    push(1, 16'h1234, 16'hABCD, 0, 1);
    run_seq(1, 0, 0, 0, 2, "n1");

`ifdef OPERAND_SEQ_ZERO_SKIP_EN
    in_a = 32'h05000700;
    wt_a = 32'h01020000;
    push(0, 16'h05, 16'h01, 0, 1);
    run_seq(0, 0, 0, 0, 2, "zskip");
    in_a = 32'h00000000;
    wt_a = 32'h0A0B0C0D;
    run_seq(0, 0, 0, 0, 1, "zskip_all_zero");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
